s2mm_sts_gen: RTL and testbench

Generates the per-packet AXI DMA S2MM status stream for the AES datapath. It snoops the handshakes on the S2MM data stream, counts the bytes accepted in each packet using the `tkeep` popcount, and queues one length per packet. For every queued length it emits a 5-word status packet on the `s_axis_s2mm_sts_*` master interface. It replaces the fixed-pattern status logic in the `axi_aes` top level and sits between the S2MM data output and the DMA status channel.

---
 rtl/s2mm_sts_gen_pkg.sv | 22 ++
 rtl/s2mm_sts_gen_fifo.sv | 61 ++++++
 rtl/s2mm_sts_gen.sv | 139 +++++++++++++
 tb/tb_s2mm_sts_gen.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2mm_sts_gen_pkg.sv
// Shared constants, FSM state type and tkeep popcount for the S2MM status generator.
package s2mm_sts_gen_pkg;

    localparam logic [31:0] C_STS_FLAG  = 32'h5000_0000;
    localparam int          C_STS_WORDS = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } sts_state_t;

    // Callers zero-extend tkeep to 64 bits, which covers data widths up to 512.
    function automatic logic [7:0] popcount(input logic [63:0] bits);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + 8'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/s2mm_sts_gen_fifo.sv
// Packet-length queue: synchronous FIFO with registered full/empty flags.
module sts_len_fifo #(
    parameter int C_DEPTH = 4,
    parameter int C_WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [C_WIDTH-1:0] din,
    input  logic               pop,
    output logic [C_WIDTH-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(C_DEPTH);

    logic [C_WIDTH-1:0] mem [C_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [AW:0]        count_next;
    logic               push_en;
    logic               pop_en;

    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count + (AW+1)'(push_en) - (AW+1)'(pop_en);
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Flags are computed from the post-edge occupancy so they stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == (AW+1)'(C_DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/s2mm_sts_gen.sv
// Per-packet AXI DMA S2MM status stream generator: counts snooped bytes per
// packet, queues the lengths and emits one 5-word status packet per length.
module s2mm_sts_gen
    import s2mm_sts_gen_pkg::*;
#(
    parameter int C_S_AXIS_S2MM_TDATA_WIDTH     = 128,
    parameter int C_S_AXIS_S2MM_STS_TDATA_WIDTH = 32,
    parameter int C_QDEPTH                      = 4,
    parameter int C_LEN_WIDTH                   = 23
) (
    input  logic                                       m_axi_s2mm_aclk,
    input  logic                                       axi_resetn,
    input  logic                                       mon_tvalid,
    input  logic                                       mon_tready,
    input  logic                                       mon_tlast,
    input  logic [C_S_AXIS_S2MM_TDATA_WIDTH/8-1:0]     mon_tkeep,
    output logic                                       q_full,
    output logic                                       len_ovf,
    output logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH-1:0]   s_axis_s2mm_sts_tdata,
    output logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH/8-1:0] s_axis_s2mm_sts_tkeep,
    output logic                                       s_axis_s2mm_sts_tvalid,
    output logic                                       s_axis_s2mm_sts_tlast,
    input  logic                                       s_axis_s2mm_sts_tready
);

    localparam logic [C_LEN_WIDTH-1:0] LEN_MAX  = '1;
    localparam logic [2:0]             IDX_LAST = 3'(C_STS_WORDS - 1);

    logic                   beat;
    logic [7:0]             beat_bytes;
    logic [C_LEN_WIDTH:0]   sum_wide;
    logic [C_LEN_WIDTH-1:0] sum_len;
    logic                   sum_sat;
    logic [C_LEN_WIDTH-1:0] acc;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_empty;
    logic [C_LEN_WIDTH:0]   fifo_dout;

    sts_state_t             state;
    logic [2:0]             idx;
    logic [2:0]             idx_next;
    logic [C_LEN_WIDTH-1:0] head_len;
    logic                   head_sat;

    function automatic logic [31:0] sts_word(input logic [2:0] i, input logic sat,
                                             input logic [C_LEN_WIDTH-1:0] len);
        logic [31:0] w;
        case (i)
            3'd0:    w = C_STS_FLAG;
            IDX_LAST: w = {sat, 8'h00, 23'(len)};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    assign beat                  = mon_tvalid & mon_tready;
    assign fifo_push             = beat & mon_tlast;
    assign fifo_pop              = (state == ST_EMIT) & s_axis_s2mm_sts_tready & (idx == IDX_LAST);
    assign idx_next              = idx + 3'd1;
    assign s_axis_s2mm_sts_tkeep = '1;

    // A length that reaches the all-ones value is reported as saturated.
    always_comb begin
        beat_bytes = popcount(64'(mon_tkeep));
        sum_wide   = {1'b0, acc} + (C_LEN_WIDTH+1)'(beat_bytes);
        sum_len    = sum_wide[C_LEN_WIDTH] ? LEN_MAX : sum_wide[C_LEN_WIDTH-1:0];
        sum_sat    = (sum_len == LEN_MAX);
    end

    always_ff @(posedge m_axi_s2mm_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            acc     <= '0;
            len_ovf <= 1'b0;
        end else if (beat) begin
            acc <= mon_tlast ? '0 : sum_len;
            if (mon_tlast && q_full) begin
                len_ovf <= 1'b1;
            end
        end
    end

    sts_len_fifo #(
        .C_DEPTH (C_QDEPTH),
        .C_WIDTH (C_LEN_WIDTH + 1)
    ) u_len_fifo (
        .clk   (m_axi_s2mm_aclk),
        .rst_n (axi_resetn),
        .push  (fifo_push),
        .din   ({sum_sat, sum_len}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (q_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge m_axi_s2mm_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state                  <= ST_IDLE;
            idx                    <= '0;
            head_len               <= '0;
            head_sat               <= 1'b0;
            s_axis_s2mm_sts_tvalid <= 1'b0;
            s_axis_s2mm_sts_tlast  <= 1'b0;
            s_axis_s2mm_sts_tdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    s_axis_s2mm_sts_tvalid <= 1'b0;
                    s_axis_s2mm_sts_tlast  <= 1'b0;
                    if (!fifo_empty) begin
                        {head_sat, head_len}   <= fifo_dout;
                        idx                    <= '0;
                        s_axis_s2mm_sts_tdata  <= C_STS_FLAG;
                        s_axis_s2mm_sts_tvalid <= 1'b1;
                        state                  <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (s_axis_s2mm_sts_tready) begin
                        if (idx == IDX_LAST) begin
                            s_axis_s2mm_sts_tvalid <= 1'b0;
                            s_axis_s2mm_sts_tlast  <= 1'b0;
                            s_axis_s2mm_sts_tdata  <= '0;
                            state                  <= ST_IDLE;
                        end else begin
                            idx                   <= idx_next;
                            s_axis_s2mm_sts_tdata <= sts_word(idx_next, head_sat, head_len);
                            s_axis_s2mm_sts_tlast <= (idx_next == IDX_LAST);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s2mm_sts_gen.sv
// Self-checking bench for s2mm_sts_gen: a scoreboard of expected status words
// is filled as packets are driven and drained by a handshake monitor.
module tb_s2mm_sts_gen;

    logic        clk;
    logic        rst_n;
    logic        mon_tvalid;
    logic        mon_tready;
    logic        mon_tlast;
    logic [15:0] mon_tkeep;
    logic        q_full;
    logic        len_ovf;
    logic [31:0] sts_tdata;
    logic [3:0]  sts_tkeep;
    logic        sts_tvalid;
    logic        sts_tlast;
    logic        sts_tready;

    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [15:0] s_tkeep;
    logic        sat_q_full;
    logic        sat_len_ovf;
    logic [31:0] sat_tdata;
    logic [3:0]  sat_tkeep;
    logic        sat_tvalid;
    logic        sat_tlast;
    logic        sat_tready;

    logic [32:0] sb [$];
    int          vectors;
    int          miscompares;
    int          hs_count;
    logic        prev_stall;
    logic [32:0] held;

    s2mm_sts_gen dut (
        .m_axi_s2mm_aclk        (clk),
        .axi_resetn             (rst_n),
        .mon_tvalid             (mon_tvalid),
        .mon_tready             (mon_tready),
        .mon_tlast              (mon_tlast),
        .mon_tkeep              (mon_tkeep),
        .q_full                 (q_full),
        .len_ovf                (len_ovf),
        .s_axis_s2mm_sts_tdata  (sts_tdata),
        .s_axis_s2mm_sts_tkeep  (sts_tkeep),
        .s_axis_s2mm_sts_tvalid (sts_tvalid),
        .s_axis_s2mm_sts_tlast  (sts_tlast),
        .s_axis_s2mm_sts_tready (sts_tready)
    );

    s2mm_sts_gen #(.C_LEN_WIDTH(6)) dut_sat (
        .m_axi_s2mm_aclk        (clk),
        .axi_resetn             (rst_n),
        .mon_tvalid             (s_tvalid),
        .mon_tready             (s_tready),
        .mon_tlast              (s_tlast),
        .mon_tkeep              (s_tkeep),
        .q_full                 (sat_q_full),
        .len_ovf                (sat_len_ovf),
        .s_axis_s2mm_sts_tdata  (sat_tdata),
        .s_axis_s2mm_sts_tkeep  (sat_tkeep),
        .s_axis_s2mm_sts_tvalid (sat_tvalid),
        .s_axis_s2mm_sts_tlast  (sat_tlast),
        .s_axis_s2mm_sts_tready (sat_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes complete at the next rising edge; sampled on the falling edge.
    always @(negedge clk) begin
        logic [32:0] exp;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (sts_tvalid !== 1'b1 || {sts_tlast, sts_tdata} !== held) begin
                    miscompares++;
                    $display("[TB] FAIL hold: got valid=%b word=%h, need valid=1 word=%h",
                             sts_tvalid, {sts_tlast, sts_tdata}, held);
                end
            end
            if (sts_tvalid && sts_tready) begin
                hs_count++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL word: got unexpected %h, need none", {sts_tlast, sts_tdata});
                end else begin
                    exp = sb.pop_front();
                    if ({sts_tlast, sts_tdata} !== exp) begin
                        miscompares++;
                        $display("[TB] FAIL word: got {tlast,tdata}=%h, need %h",
                                 {sts_tlast, sts_tdata}, exp);
                    end
                end
            end
            prev_stall = sts_tvalid && !sts_tready;
            held       = {sts_tlast, sts_tdata};
        end
    end

    task automatic push_pkt(input logic [22:0] len, input logic sat);
        sb.push_back({1'b0, 32'h5000_0000});
        for (int i = 0; i < 3; i++) sb.push_back({1'b0, 32'h0});
        sb.push_back({1'b1, sat, 8'h00, len});
    endtask

    task automatic send_beat(input logic [15:0] keep, input logic last, input logic rdy = 1'b1);
        mon_tvalid = 1'b1;
        mon_tready = rdy;
        mon_tkeep  = keep;
        mon_tlast  = last;
        @(posedge clk); #1;
        mon_tvalid = 1'b0;
        mon_tlast  = 1'b0;
        mon_tkeep  = '0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || sts_tvalid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (sb.size() != 0 || sts_tvalid) begin
            miscompares++;
            $display("[TB] FAIL %s_drain: got %0d words outstanding, need 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors += 7;
        if (sts_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_tvalid: got %b need 0", sts_tvalid); end
        if (sts_tlast !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_tlast: got %b need 0", sts_tlast); end
        if (sts_tdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_tdata: got %h need 0", sts_tdata); end
        if (q_full !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_q_full: got %b need 0", q_full); end
        if (len_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_len_ovf: got %b need 0", len_ovf); end
        if (sts_tkeep !== 4'hf) begin miscompares++; $display("[TB] FAIL rst_tkeep: got %h need f", sts_tkeep); end
        if (sat_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_sat_tvalid: got %b need 0", sat_tvalid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_packet();
        sts_tready = 1'b1;
        push_pkt(23'h28, 1'b0);
        send_beat(16'hffff, 1'b0);
        send_beat(16'hffff, 1'b0);
        send_beat(16'h00ff, 1'b1);
        vectors++;
        if (sts_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_early: got tvalid=%b need 0", sts_tvalid); end
        @(posedge clk); #1;
        vectors++;
        if (sts_tvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL latency: got tvalid=%b need 1", sts_tvalid); end
        drain("single");
    endtask

    task automatic test_zero_length();
        sts_tready = 1'b1;
        push_pkt(23'h0, 1'b0);
        send_beat(16'h0000, 1'b1);
        push_pkt(23'h80, 1'b0);
        for (int i = 0; i < 8; i++) send_beat(16'hffff, i == 7);
        drain("zero_len");
    endtask

    task automatic test_back_to_back();
        sts_tready = 1'b1;
        push_pkt(23'h05, 1'b0);
        send_beat(16'h001f, 1'b1);
        push_pkt(23'h23, 1'b0);
        send_beat(16'hffff, 1'b0);
        send_beat(16'hffff, 1'b1, 1'b0);
        send_beat(16'hffff, 1'b0);
        send_beat(16'h0007, 1'b1);
        drain("b2b");
        vectors += 2;
        if (q_full !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_q_full: got %b need 0", q_full); end
        if (len_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_len_ovf: got %b need 0", len_ovf); end
    endtask

    task automatic test_backpressure();
        int base;
        int n;
        sts_tready = 1'b0;
        push_pkt(23'h20, 1'b0);
        send_beat(16'hffff, 1'b0);
        send_beat(16'hffff, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        base = hs_count;
        sts_tready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        sts_tready = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        vectors++;
        if (hs_count - base !== 2) begin miscompares++; $display("[TB] FAIL bp_stall: got %0d handshakes need 2", hs_count - base); end
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            sts_tready = ~sts_tready;
            @(posedge clk); #1;
            n++;
        end
        sts_tready = 1'b1;
        drain("bp");
        vectors++;
        if (hs_count - base !== 5) begin miscompares++; $display("[TB] FAIL bp_count: got %0d handshakes need 5", hs_count - base); end
    endtask

    task automatic test_queue_full();
        sts_tready = 1'b0;
        for (int i = 0; i < 4; i++) push_pkt(23'h10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_beat(16'hffff, 1'b1);
            if (i == 2) begin
                vectors++;
                if (q_full !== 1'b0) begin miscompares++; $display("[TB] FAIL qf_3: got q_full=%b need 0", q_full); end
            end
            if (i == 3) begin
                vectors += 2;
                if (q_full !== 1'b1) begin miscompares++; $display("[TB] FAIL qf_4: got q_full=%b need 1", q_full); end
                if (len_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL qf_ovf4: got len_ovf=%b need 0", len_ovf); end
            end
        end
        vectors += 2;
        if (q_full !== 1'b1) begin miscompares++; $display("[TB] FAIL qf_5: got q_full=%b need 1", q_full); end
        if (len_ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL qf_ovf5: got len_ovf=%b need 1", len_ovf); end
        sts_tready = 1'b1;
        drain("qfull");
        vectors += 2;
        if (q_full !== 1'b0) begin miscompares++; $display("[TB] FAIL qf_after: got q_full=%b need 0", q_full); end
        if (len_ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL qf_sticky: got len_ovf=%b need 1", len_ovf); end
    endtask

    task automatic sat_beat(input logic [15:0] keep, input logic last);
        s_tvalid = 1'b1;
        s_tkeep  = keep;
        s_tlast  = last;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tkeep  = '0;
    endtask

    task automatic test_saturation();
        logic [31:0] need [2];
        need[0] = 32'h8000_003f;
        need[1] = 32'h0000_002f;
        for (int p = 0; p < 2; p++) begin
            int n;
            if (p == 0) begin
                for (int i = 0; i < 5; i++) sat_beat(16'hffff, i == 4);
            end else begin
                sat_beat(16'hffff, 1'b0);
                sat_beat(16'hffff, 1'b0);
                sat_beat(16'h7fff, 1'b1);
            end
            n = 0;
            while (!(sat_tvalid && sat_tlast) && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            vectors++;
            if (!(sat_tvalid && sat_tlast)) begin
                miscompares++;
                $display("[TB] FAIL sat_timeout: got no word 4, need %h", need[p]);
            end else if (sat_tdata !== need[p]) begin
                miscompares++;
                $display("[TB] FAIL sat_word4: got %h need %h", sat_tdata, need[p]);
            end
            repeat (2) begin @(posedge clk); #1; end
        end
        vectors++;
        if (sat_len_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_ovf: got %b need 0", sat_len_ovf); end
    endtask

    task automatic test_reset_mid_packet();
        int base;
        int n;
        sts_tready = 1'b1;
        sb.push_back({1'b0, 32'h5000_0000});
        sb.push_back({1'b0, 32'h0});
        base = hs_count;
        send_beat(16'hffff, 1'b1);
        n = 0;
        while (hs_count < base + 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        sts_tready = 1'b0;
        vectors++;
        if (hs_count - base !== 2) begin miscompares++; $display("[TB] FAIL rm_pre: got %0d handshakes need 2", hs_count - base); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors += 5;
        if (sts_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_tvalid: got %b need 0", sts_tvalid); end
        if (sts_tlast !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_tlast: got %b need 0", sts_tlast); end
        if (sts_tdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rm_tdata: got %h need 0", sts_tdata); end
        if (q_full !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_q_full: got %b need 0", q_full); end
        if (len_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_len_ovf: got %b need 0", len_ovf); end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        sts_tready = 1'b1;
        push_pkt(23'h04, 1'b0);
        send_beat(16'h000f, 1'b1);
        drain("rm_after");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        hs_count    = 0;
        prev_stall  = 1'b0;
        held        = '0;
        rst_n       = 1'b0;
        mon_tvalid  = 1'b0;
        mon_tready  = 1'b0;
        mon_tlast   = 1'b0;
        mon_tkeep   = '0;
        sts_tready  = 1'b0;
        s_tvalid    = 1'b0;
        s_tready    = 1'b1;
        s_tlast     = 1'b0;
        s_tkeep     = '0;
        sat_tready  = 1'b1;

        test_reset();
        test_single_packet();
        test_zero_length();
        test_back_to_back();
        test_backpressure();
        test_queue_full();
        test_saturation();
        test_reset_mid_packet();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
